afifo_wr_arb: RTL and testbench
===============================

# afifo_wr_arb

Write-side packet arbiter that shares one async FIFO (wr_clk domain) among NREQ requesters. Grants whole packets in round-robin order and admits a new packet only while the FIFO is not almost-full. Per beat it throttles on the FIFO's look-ahead `full` and drives registered `wr`/`wr_dat` tagged with source ID, last and error bits. Sits directly in front of the FIFO write port.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `BITWID`, default 8: payload width per requester.
- `IDW`, default 2: source-ID width, equal to clog2(NREQ).
- `OWID`, default BITWID+IDW+2: FIFO word width.
- `wr_clk`  in  1  write-domain clock.
- `wr_rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  NREQ  per-requester beat valid.
- `s_last`  in  NREQ  per-requester last beat of packet.
- `s_data`  in  NREQ*BITWID  payloads; requester i is at [i*BITWID +: BITWID].
- `s_ready`  out  NREQ  per-requester beat accept.
- `fifo_full`  in  1  FIFO full, look-ahead: includes the write in flight this cycle.
- `fifo_almost_full`  in  1  FIFO almost_full.
- `cfg_timeout`  in  16  watchdog stall limit in cycles; 0 disables.
- `wr`  out  1  FIFO write strobe, registered.
- `wr_dat`  out  OWID  {err, last, src_id, data}, registered.
- `grant`  out  NREQ  one-hot current owner; 0 when idle.
- `busy`  out  1  packet in progress.
- `timeout_evt`  out  1  one-cycle pulse when a watchdog abort is issued.

## Operation
- FSM states: IDLE, PKT.
- IDLE to PKT: when any `s_valid` is high and `fifo_almost_full` is 0.
  - Winner is the first valid requester searched from rr_ptr+1 with wrap-around.
  - On that edge: `grant` is loaded with the winner and rr_ptr is loaded with the winner index.
- PKT, beat transfer:
  - `s_ready[i]` = `grant[i]` & !`fifo_full`, combinational.
  - A beat transfers when `s_valid` & `s_ready` for the granted requester.
- PKT to IDLE: on a transferred beat with `s_last`=1. `grant` clears on the same edge.
- While in PKT, other requesters are ignored; the granted packet is never preempted.
- Each transferred beat registers `wr`=1 and `wr_dat` = {1'b0, s_last, id, s_data}.
- If no beat transfers, `wr`=0 and `wr_dat` holds its previous value.
- `busy` is high exactly when the FSM is in PKT.
- `fifo_full` during cycle t already accounts for `wr` in cycle t. Issuing only when !full therefore never overflows, and there is no combinational loop through `wr`.
- Reset values: FSM IDLE; rr_ptr = NREQ-1, so requester 0 wins first; `grant`=0, `s_ready`=0, `wr`=0, `wr_dat`=0, `busy`=0, `timeout_evt`=0; watchdog counter = 0.
- When `wr_rst_n` asserts mid-packet, the packet is dropped and no terminating word is written. The FIFO's own reset realigns its pointers.

## Timing
- Request at cycle t in IDLE: `grant`/`s_ready` high at t+1 (if !full), first `wr` at t+2.
- Throughput is one beat per cycle within a packet.
- There is one IDLE bubble cycle between packets.
- `s_ready` falls in the same cycle `fifo_full` rises; `wr` drops one cycle later.
- `fifo_almost_full` gates only packet admission, never beats inside a packet.

## Configuration
- `AFIFO_ARB_WATCHDOG_EN` defined:
  - A 16-bit counter counts PKT cycles where the granted `s_valid`=0 and resets on every transferred beat.
  - When the counter reaches `cfg_timeout` (nonzero) and !`fifo_full`, the block writes a terminating word {1, 1, id, 0}, pulses `timeout_evt`, returns to IDLE and clears `grant`.
  - If `fifo_full` is high at that point, the abort waits until it clears.
- `AFIFO_ARB_WATCHDOG_EN` undefined: no counter; err bit is always 0; `timeout_evt` is tied 0; `cfg_timeout` is ignored.

## Structure
- Package `afifo_arb_pkg` holds:
  - FSM state enum (IDLE, PKT).
  - Word field offsets: ERR_BIT, LAST_BIT, ID_LSB.
  - Function `rr_pick(req, ptr)`, returning the index and a found flag.
- Sub-module `afifo_rr_arb`: combinational round-robin picker plus registered rr_ptr, instantiated once.

## Test plan
Configuration for all cases: NREQ=4, BITWID=8, async FIFO DEEPWID=3 (depth 8), almost-full threshold 6.
- Reset release, requesters 1 and 3 each with a 2-beat packet (0x11,0x12 / 0x31,0x32) → FIFO words in order id1:0x11, id1:0x12+last, id3:0x31, id3:0x32+last.
- All four requesters continuously offer 1-beat packets → grant order 0,1,2,3,0,… with no requester starved across 8 packets.
- Requester 0 sends a 10-beat packet with the read side stalled → exactly 8 beats written, `s_ready`=0 with `full`; after 2 reads the remaining 2 beats complete and nothing is lost or duplicated.
- FIFO holding 6 words (almost_full), requester 2 valid → no grant until one read drops almost_full, then grant at the next cycle.
- Watchdog enabled, `cfg_timeout`=5, requester 1 sends 1 beat with last=0 then drops valid → after 5 idle cycles word {err=1, last=1, id=1, 0x00} is written, `timeout_evt` pulses once, and requester 2 is granted next.
- `wr_rst_n` asserted mid-packet → all outputs 0 on the next cycle, FSM IDLE, and requester 0 wins first after release.

Source files
------------

// File: rtl/afifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
package afifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    localparam int MAX_REQ = 16;

    // Tag offsets above the payload: ID starts right after the data, LAST/ERR sit above the ID
    localparam int ID_LSB   = 0;
    localparam int LAST_BIT = 0;
    localparam int ERR_BIT  = 1;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First set bit of req searched from ptr+1 upwards, wrapping at n; ptr itself is checked last.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [3:0]         ptr,
                                      input int                 n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = n; k >= 1; k--) begin
            j = (int'(ptr) + k) % n;
            if (req[j]) begin
                p.found = 1'b1;
                p.idx   = 4'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/afifo_rr_arb.sv
// Round-robin picker with the registered pointer of the last granted requester.
module afifo_rr_arb
    import afifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            wr_clk,
    input  logic            wr_rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            load_i,
    output logic [IDW-1:0]  pick_idx_o,
    output logic            pick_vld_o,
    output logic [IDW-1:0]  rr_ptr_o
);

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    pick_t          pick;

    assign pick       = rr_pick(MAX_REQ'(req_i), 4'(rr_ptr_q), NREQ);
    assign pick_idx_o = IDW'(pick.idx);
    assign pick_vld_o = pick.found;
    assign rr_ptr_d   = load_i ? pick_idx_o : rr_ptr_q;
    assign rr_ptr_o   = rr_ptr_q;

    // Reset to the last index so requester 0 is searched first
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            rr_ptr_q <= IDW'(NREQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/afifo_wr_arb.sv
// Packet-granular round-robin arbiter driving one async FIFO write port.
// Define AFIFO_ARB_WATCHDOG_EN to build in the stalled-packet watchdog abort.
module afifo_wr_arb
    import afifo_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int BITWID = 8,
    parameter int IDW    = $clog2(NREQ),
    parameter int OWID   = BITWID + IDW + 2
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst_n,
    input  logic [NREQ-1:0]        s_valid,
    input  logic [NREQ-1:0]        s_last,
    input  logic [NREQ*BITWID-1:0] s_data,
    output logic [NREQ-1:0]        s_ready,
    input  logic                   fifo_full,
    input  logic                   fifo_almost_full,
    input  logic [15:0]            cfg_timeout,
    output logic                   wr,
    output logic [OWID-1:0]        wr_dat,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   timeout_evt
);

    state_t            state_q;
    logic [NREQ-1:0]   grant_q;
    logic              wr_q;
    logic [OWID-1:0]   wr_dat_q;
    logic [IDW-1:0]    own_id;
    logic [IDW-1:0]    pick_idx;
    logic              pick_vld;
    logic              admit;
    logic              own_valid;
    logic              own_last;
    logic [BITWID-1:0] own_data;
    logic              beat;

    function automatic logic [OWID-1:0] pack_word(input logic              err,
                                                  input logic              last,
                                                  input logic [IDW-1:0]    id,
                                                  input logic [BITWID-1:0] data);
        logic [OWID-1:0] w;
        w                              = '0;
        w[BITWID-1:0]                  = data;
        w[BITWID+ID_LSB +: IDW]        = id;
        w[BITWID+IDW+LAST_BIT]         = last;
        w[BITWID+IDW+ERR_BIT]          = err;
        return w;
    endfunction

    // The arbiter's pointer doubles as the owner index while a packet is open
    afifo_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .wr_clk     (wr_clk),
        .wr_rst_n   (wr_rst_n),
        .req_i      (s_valid),
        .load_i     (admit),
        .pick_idx_o (pick_idx),
        .pick_vld_o (pick_vld),
        .rr_ptr_o   (own_id)
    );

    assign admit     = (state_q == IDLE) && pick_vld && !fifo_almost_full;
    assign own_valid = s_valid[own_id];
    assign own_last  = s_last[own_id];
    assign own_data  = s_data[int'(own_id)*BITWID +: BITWID];
    assign beat      = (state_q == PKT) && own_valid && !fifo_full;

    assign s_ready = grant_q & {NREQ{~fifo_full}};
    assign wr      = wr_q;
    assign wr_dat  = wr_dat_q;
    assign grant   = grant_q;
    assign busy    = (state_q == PKT);

`ifdef AFIFO_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt_q;
    logic        evt_q;
    logic        wd_expired;

    assign wd_expired  = (cfg_timeout != 16'd0) && (wd_cnt_q == cfg_timeout);
    assign timeout_evt = evt_q;
`else
    logic unused_cfg;

    assign unused_cfg  = ^cfg_timeout;
    assign timeout_evt = 1'b0;
`endif

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            wr_q     <= 1'b0;
            wr_dat_q <= '0;
`ifdef AFIFO_ARB_WATCHDOG_EN
            wd_cnt_q <= '0;
            evt_q    <= 1'b0;
`endif
        end else begin
            wr_q <= 1'b0;
`ifdef AFIFO_ARB_WATCHDOG_EN
            evt_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (admit) begin
                        state_q <= PKT;
                        grant_q <= NREQ'(1) << pick_idx;
`ifdef AFIFO_ARB_WATCHDOG_EN
                        wd_cnt_q <= '0;
`endif
                    end
                end
                PKT: begin
                    if (beat) begin
                        wr_q     <= 1'b1;
                        wr_dat_q <= pack_word(1'b0, own_last, own_id, own_data);
`ifdef AFIFO_ARB_WATCHDOG_EN
                        wd_cnt_q <= '0;
`endif
                        if (own_last) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end
`ifdef AFIFO_ARB_WATCHDOG_EN
                    // A pending abort holds its count until the FIFO can take the terminator
                    else if (wd_expired) begin
                        if (!fifo_full) begin
                            wr_q     <= 1'b1;
                            wr_dat_q <= pack_word(1'b1, 1'b1, own_id, '0);
                            evt_q    <= 1'b1;
                            state_q  <= IDLE;
                            grant_q  <= '0;
                        end
                    end else if (!own_valid) begin
                        wd_cnt_q <= wd_cnt_q + 16'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Bench for afifo_wr_arb: behavioural FIFO, requester sources and a packet-level reference model.
module tb_afifo_wr_arb;

    localparam int NREQ     = 4;
    localparam int BITWID   = 8;
    localparam int IDW      = 2;
    localparam int OWID     = BITWID + IDW + 2;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;

    typedef logic [BITWID:0] beat_t;

    logic                   wr_clk   = 1'b0;
    logic                   wr_rst_n = 1'b1;
    logic [NREQ-1:0]        s_valid;
    logic [NREQ-1:0]        s_last;
    logic [NREQ*BITWID-1:0] s_data;
    logic [NREQ-1:0]        s_ready;
    logic                   fifo_full;
    logic                   fifo_almost_full;
    logic [15:0]            cfg_timeout;
    logic                   wr;
    logic [OWID-1:0]        wr_dat;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   timeout_evt;

    afifo_wr_arb #(
        .NREQ   (NREQ),
        .BITWID (BITWID),
        .IDW    (IDW),
        .OWID   (OWID)
    ) dut (
        .wr_clk           (wr_clk),
        .wr_rst_n         (wr_rst_n),
        .s_valid          (s_valid),
        .s_last           (s_last),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .cfg_timeout      (cfg_timeout),
        .wr               (wr),
        .wr_dat           (wr_dat),
        .grant            (grant),
        .busy             (busy),
        .timeout_evt      (timeout_evt)
    );

    always #5 wr_clk = ~wr_clk;

    int              checks = 0;
    int              errors = 0;
    beat_t           src_q   [NREQ][$];
    beat_t           exp_src [NREQ][$];
    logic [NREQ-1:0] presenting = '0;
    int              gap_pct = 0;
    logic [OWID-1:0] fifo_q[$];
    logic [OWID-1:0] popped[$];
    logic            rd_en = 1'b0;
    int              wr_count = 0;
    int              evt_count = 0;
    int              dut_admits[$];
    logic            busy_prev = 1'b0;

    logic            m_busy;
    int              m_owner;
    int              m_last;
    logic [15:0]     m_cnt;
    logic [OWID-1:0] m_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OWID-1:0] word(input logic err, input logic last, input int id,
                                             input logic [BITWID-1:0] d);
        return {err, last, 2'(id), d};
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (g == (4'b1 << i)) r = i;
        return r;
    endfunction

    function automatic logic src_empty();
        logic e = (presenting == '0);
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_cnt   = '0;
        m_dat   = '0;
    endtask

    task automatic cycle();
        logic [NREQ-1:0]   v_s, l_s, rdy_s;
        logic              full_s, af_s, exp_wr, exp_evt, found;
        logic [BITWID-1:0] d;
        @(negedge wr_clk);
        if (rd_en && fifo_q.size() > 0) popped.push_back(fifo_q.pop_front());
        fifo_full        = (fifo_q.size() >= DEPTH);
        fifo_almost_full = (fifo_q.size() >= AF_LEVEL);
        for (int i = 0; i < NREQ; i++) begin
            if (!presenting[i] && src_q[i].size() > 0 && $urandom_range(99) >= gap_pct)
                presenting[i] = 1'b1;
            s_valid[i] = presenting[i];
            if (presenting[i]) begin
                s_last[i]                    = src_q[i][0][BITWID];
                s_data[i*BITWID +: BITWID]   = src_q[i][0][BITWID-1:0];
            end else begin
                s_last[i]                    = 1'($urandom);
                s_data[i*BITWID +: BITWID]   = 8'($urandom);
            end
        end
        #1;
        v_s = s_valid; l_s = s_last; rdy_s = s_ready; full_s = fifo_full; af_s = fifo_almost_full;
        chk("s_ready", 32'(s_ready), 32'(m_busy && !full_s ? (4'b1 << m_owner) : 4'b0));

        exp_wr = 1'b0; exp_evt = 1'b0;
        if (!m_busy) begin
            if (v_s != '0 && !af_s) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && v_s[(m_last + k) % NREQ]) begin
                        found   = 1'b1;
                        m_owner = (m_last + k) % NREQ;
                    end
                end
                m_last = m_owner; m_busy = 1'b1; m_cnt = '0;
            end
        end else begin
            d = s_data[m_owner*BITWID +: BITWID];
            if (v_s[m_owner] && !full_s) begin
                exp_wr = 1'b1; m_dat = word(1'b0, l_s[m_owner], m_owner, d); m_cnt = '0;
                if (l_s[m_owner]) m_busy = 1'b0;
            end
`ifdef AFIFO_ARB_WATCHDOG_EN
            else if (cfg_timeout != 0 && m_cnt == cfg_timeout) begin
                if (!full_s) begin
                    exp_wr = 1'b1; exp_evt = 1'b1; m_busy = 1'b0;
                    m_dat = word(1'b1, 1'b1, m_owner, 8'h00);
                end
            end else if (!v_s[m_owner]) m_cnt = m_cnt + 16'd1;
`endif
        end

        @(posedge wr_clk); #1;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant", 32'(grant), 32'(m_busy ? (4'b1 << m_owner) : 4'b0));
        chk("wr", 32'(wr), 32'(exp_wr));
        chk("wr_dat", 32'(wr_dat), 32'(m_dat));
        chk("timeout_evt", 32'(timeout_evt), 32'(exp_evt));
        if (busy && !busy_prev) dut_admits.push_back(onehot_idx(grant));
        busy_prev = busy;
        if (wr) begin fifo_q.push_back(wr_dat); wr_count++; end
        if (timeout_evt) evt_count++;
        for (int i = 0; i < NREQ; i++) begin
            if (v_s[i] && rdy_s[i]) begin
                void'(src_q[i].pop_front());
                presenting[i] = 1'b0;
            end
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge wr_clk); #2;
        wr_rst_n = 1'b0; s_valid = '0;
        #1;
        chk({tag, "_wr"}, 32'(wr), 32'd0);
        chk({tag, "_wr_dat"}, 32'(wr_dat), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_evt"}, 32'(timeout_evt), 32'd0);
        chk({tag, "_ready"}, 32'(s_ready), 32'd0);
        presenting = '0;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        fifo_q.delete();
        model_reset();
        busy_prev = 1'b0;
        @(posedge wr_clk); #1;
        chk({tag, "_busy_next"}, 32'(busy), 32'd0);
        chk({tag, "_wr_next"}, 32'(wr), 32'd0);
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        rd_en = 1'b1;
        while (n < budget && !(fifo_q.size() == 0 && !m_busy && busy == 1'b0 && src_empty())) begin
            cycle();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int               n, cnt, viol, cur, len;
        logic [OWID-1:0]  wv;
        logic [BITWID:0]  b;
        s_valid = '0; s_last = '0; s_data = '0;
        fifo_full = 1'b0; fifo_almost_full = 1'b0; cfg_timeout = 16'd0;
        model_reset();
        apply_reset("rst0");

        // Two 2-beat packets from requesters 1 and 3 with the read side held
        rd_en = 1'b0;
        src_q[1].push_back(9'h011); src_q[1].push_back(9'h112);
        src_q[3].push_back(9'h031); src_q[3].push_back(9'h132);
        n = 0;
        while (n < 40 && !(fifo_q.size() == 4 && src_empty() && !m_busy)) begin cycle(); n++; end
        chk("t1_done", 32'(n < 40), 32'd1);
        chk("t1_w0", 32'(fifo_q.size() > 0 ? fifo_q[0] : '0), 32'(word(0, 0, 1, 8'h11)));
        chk("t1_w1", 32'(fifo_q.size() > 1 ? fifo_q[1] : '0), 32'(word(0, 1, 1, 8'h12)));
        chk("t1_w2", 32'(fifo_q.size() > 2 ? fifo_q[2] : '0), 32'(word(0, 0, 3, 8'h31)));
        chk("t1_w3", 32'(fifo_q.size() > 3 ? fifo_q[3] : '0), 32'(word(0, 1, 3, 8'h32)));
        drain("t1_drain", 40);

        // Everyone offering single-beat packets: strict rotation from requester 0
        dut_admits.delete();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 2; k++) src_q[i].push_back({1'b1, 4'(i), 4'(k)});
        drain("t2_drain", 80);
        for (int k = 0; k < 8; k++)
            chk("t2_order", 32'(dut_admits.size() > k ? dut_admits[k] : -1), 32'(k % NREQ));

        // 10-beat packet into a stalled FIFO of depth 8
        rd_en = 1'b0; popped.delete(); wr_count = 0;
        for (int k = 0; k < 10; k++) src_q[0].push_back({1'(k == 9), 8'hA0 + 8'(k)});
        repeat (20) cycle();
        chk("t3_wr_count", 32'(wr_count), 32'd8);
        chk("t3_fill", 32'(fifo_q.size()), 32'd8);
        chk("t3_ready_low", 32'(s_ready), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        rd_en = 1'b1; cycle(); cycle(); rd_en = 1'b0;
        repeat (6) cycle();
        chk("t3_total", 32'(wr_count), 32'd10);
        chk("t3_idle", 32'(busy), 32'd0);
        for (int k = 0; k < 10; k++) begin
            wv = (k < popped.size()) ? popped[k] :
                 ((k - popped.size()) < fifo_q.size() ? fifo_q[k - popped.size()] : '0);
            chk("t3_word", 32'(wv), 32'(word(0, 1'(k == 9), 0, 8'hA0 + 8'(k))));
        end

        // Almost-full blocks admission until a read frees a slot
        rd_en = 1'b1; cycle(); cycle(); rd_en = 1'b0;
        chk("t4_level", 32'(fifo_q.size()), 32'd6);
        src_q[2].push_back(9'h12C);
        repeat (4) cycle();
        chk("t4_hold", 32'(grant), 32'd0);
        rd_en = 1'b1; cycle(); rd_en = 1'b0;
        chk("t4_grant", 32'(grant), 32'b0100);
        drain("t4_drain", 60);

        // Requester 1 stalls mid-packet while requester 2 waits
        popped.delete(); dut_admits.delete(); evt_count = 0;
        cfg_timeout = 16'd5;
        src_q[1].push_back(9'h055);
        src_q[2].push_back(9'h166);
        repeat (15) cycle();
        cnt = 0;
        foreach (popped[k]) if (popped[k] == word(1, 1, 1, 8'h00)) cnt++;
        foreach (fifo_q[k]) if (fifo_q[k] == word(1, 1, 1, 8'h00)) cnt++;
`ifdef AFIFO_ARB_WATCHDOG_EN
        chk("t5_evt_count", 32'(evt_count), 32'd1);
        chk("t5_abort_word", 32'(cnt), 32'd1);
`else
        chk("t5_evt_count", 32'(evt_count), 32'd0);
        chk("t5_abort_word", 32'(cnt), 32'd0);
        chk("t5_stuck", 32'(busy), 32'd1);
`endif
        src_q[1].push_back(9'h156);
        drain("t5_drain", 60);
        chk("t5_first", 32'(dut_admits.size() > 0 ? dut_admits[0] : -1), 32'd1);
        chk("t5_next", 32'(dut_admits.size() > 1 ? dut_admits[1] : -1), 32'd2);
        cfg_timeout = 16'd0;

        // Reset in the middle of a packet
        for (int k = 0; k < 5; k++) src_q[3].push_back({1'(k == 4), 8'hD0 + 8'(k)});
        repeat (4) cycle();
        chk("t6_busy", 32'(busy), 32'd1);
        apply_reset("t6");
        dut_admits.delete();
        for (int i = 0; i < NREQ; i++) src_q[i].push_back({1'b1, 8'hE0 + 8'(i)});
        drain("t6_drain", 60);
        chk("t6_first", 32'(dut_admits.size() > 0 ? dut_admits[0] : -1), 32'd0);

        // Random packets, random source gaps and random read stalls
        popped.delete();
        gap_pct = 30;
        for (int i = 0; i < NREQ; i++) begin
            exp_src[i].delete();
            for (int p = 0; p < 6; p++) begin
                len = $urandom_range(4, 1);
                for (int k = 0; k < len; k++) begin
                    b = {1'(k == len - 1), 8'($urandom)};
                    src_q[i].push_back(b);
                    exp_src[i].push_back(b);
                end
            end
        end
        n = 0;
        while (n < 3000 && !(src_empty() && !m_busy)) begin
            rd_en = ($urandom_range(99) < 70);
            cycle();
            n++;
        end
        chk("t7_done", 32'(n < 3000), 32'd1);
        drain("t7_drain", 100);
        for (int i = 0; i < NREQ; i++) begin
            cnt = 0;
            foreach (popped[k]) begin
                if (int'(popped[k][BITWID +: IDW]) == i) begin
                    chk("t7_beat", 32'(popped[k]),
                        32'(cnt < exp_src[i].size() ?
                            word(0, exp_src[i][cnt][BITWID], i, exp_src[i][cnt][BITWID-1:0]) : '1));
                    cnt++;
                end
            end
            chk("t7_count", 32'(cnt), 32'(exp_src[i].size()));
        end
        viol = 0; cur = -1;
        foreach (popped[k]) begin
            if (cur != -1 && int'(popped[k][BITWID +: IDW]) != cur) viol++;
            cur = popped[k][BITWID+IDW] ? -1 : int'(popped[k][BITWID +: IDW]);
        end
        chk("t7_contiguous", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
